// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//
// Fetch program-counter register with redirect handling for a five-stage
// pipeline. Redirects (JR/JALR, J/JAL, taken branch) are resolved in decode
// and steer the next fetch address. A redirect that arrives while fetch is
// stalled is parked in a one-entry pend buffer and applied on stall release.
//
// Parameters
//   RESET_PC          fetch PC loaded while reset is asserted
//
// Ports
//   clk               single clock, all state updates on its rising edge
//   rst               synchronous active-low reset
//   stall_f           fetch stall, PC is held
//   jump_en           J/JAL resolved in decode
//   jump_addr28       word-shifted instr_index, {index, 2'b00}
//   pc_plus4_d        decode-stage PC+4, supplies jump target bits [31:28]
//   branch_en         taken branch resolved in decode
//   branch_target     branch destination
//   jr_en             JR/JALR resolved in decode
//   jr_target         register jump destination
//   pc_f              current fetch PC
//   pc_plus4_f        pc_f + 4 (combinational, wraps at 2^32)
//   flush_d           registered one-cycle pulse killing the wrong-path decode instr
//   redirect_pending  a redirect is buffered awaiting stall release
//   addr_err          sticky flag: a misaligned register-jump target was accepted
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | normal fetch; redirects applied directly or parked if stalled
// HOLD_PEND  | redirect parked in pend buffer; waiting for stall_f to drop

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        jump_en,
  input  logic [27:0] jump_addr28,
  input  logic [31:0] pc_plus4_d,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        flush_d,
  output logic        redirect_pending,
  output logic        addr_err
);

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_HOLD_PEND = 1'b1;

  logic [0:0]  state;
  logic        pend_valid;
  logic [31:0] pend_target;

  logic        redirect_req;
  logic        redirect_misaligned;
  logic [31:0] redirect_raw;
  logic [31:0] redirect_target;

  // Only the region bits of decode PC+4 form part of the jump target.
  logic        unused_pc_plus4_low;
  assign unused_pc_plus4_low = ^pc_plus4_d[27:0];

  // Redirect source select, priority jr > jump > branch. Only a register
  // jump can carry a misaligned address; the other targets are word
  // addresses by construction and are silently aligned.
  always_comb begin
    redirect_req        = jr_en | jump_en | branch_en;
    redirect_raw        = branch_target;
    redirect_misaligned = 1'b0;
    if (jr_en) begin
      redirect_raw        = jr_target;
      redirect_misaligned = |jr_target[1:0];
    end else if (jump_en) begin
      redirect_raw = {pc_plus4_d[31:28], jump_addr28};
    end
  end

  assign redirect_target  = redirect_raw & 32'hFFFF_FFFC;
  assign pc_plus4_f       = pc_f + 32'd4;
  assign redirect_pending = pend_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      pc_f        <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0000_0000;
      flush_d     <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      flush_d <= 1'b0;
      case (state)
        ST_RUN: begin
          if (redirect_req) begin
            if (redirect_misaligned) begin
              addr_err <= 1'b1;
            end
            if (stall_f) begin
              // Park the redirect; flush is deferred until it is applied.
              pend_target <= redirect_target;
              pend_valid  <= 1'b1;
              state       <= ST_HOLD_PEND;
            end else begin
              pc_f    <= redirect_target;
              flush_d <= 1'b1;
            end
          end else if (!stall_f) begin
            pc_f <= pc_plus4_f;
          end
        end
        ST_HOLD_PEND: begin
          // Decode is frozen while stalled, so any request seen here is the
          // same instruction already buffered; new requests are ignored.
          if (!stall_f) begin
            pc_f       <= pend_target;
            flush_d    <= 1'b1;
            pend_valid <= 1'b0;
            state      <= ST_RUN;
          end
        end
        default: begin
          state      <= ST_RUN;
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        jump_en;
  logic [27:0] jump_addr28;
  logic [31:0] pc_plus4_d;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        flush_d;
  logic        redirect_pending;
  logic        addr_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: fetch PC, a queue holding at most one parked target,
  // last-edge flush indication and the sticky error flag.
  logic [31:0] m_pc;
  logic [31:0] m_pend_q[$];
  logic        m_flush;
  logic        m_err;

  pc_redirect_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .jump_en(jump_en),
    .jump_addr28(jump_addr28), .pc_plus4_d(pc_plus4_d), .branch_en(branch_en),
    .branch_target(branch_target), .jr_en(jr_en), .jr_target(jr_target),
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .flush_d(flush_d),
    .redirect_pending(redirect_pending), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic        have;
    logic [31:0] tgt;
    if (!rst) begin
      m_pc = RESET_PC;
      m_pend_q.delete();
      m_flush = 1'b0;
      m_err = 1'b0;
    end else begin
      m_flush = 1'b0;
      if (m_pend_q.size() != 0) begin
        if (!stall_f) begin
          m_pc = m_pend_q.pop_front();
          m_flush = 1'b1;
        end
      end else begin
        have = 1'b1;
        tgt = 32'h0;
        if (jr_en) begin
          tgt = jr_target;
          if (jr_target % 4 != 0) m_err = 1'b1;
        end else if (jump_en) begin
          tgt = {pc_plus4_d[31:28], jump_addr28};
        end else if (branch_en) begin
          tgt = branch_target;
        end else begin
          have = 1'b0;
        end
        tgt = tgt - (tgt % 4);
        if (have) begin
          if (stall_f) m_pend_q.push_back(tgt);
          else begin
            m_pc = tgt;
            m_flush = 1'b1;
          end
        end else if (!stall_f) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_req();
    jump_en = 1'b0; branch_en = 1'b0; jr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_f = 1'b0; clear_req();
    jump_addr28 = '0; pc_plus4_d = '0; branch_target = '0; jr_target = '0;
    cycle(); cycle();
    vectors++; if (pc_f !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc_f, RESET_PC); end
    vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b expected 0", flush_d); end
    vectors++; if (redirect_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b expected 0", redirect_pending); end
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", addr_err); end
  endtask

  task automatic test_sequential();
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      vectors++; if (pc_f !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc_f, 32'(4 * i)); end
      vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL seq_flush%0d: got %b expected 0", i, flush_d); end
    end
  endtask

  task automatic test_jump();
    jump_en = 1'b1; jump_addr28 = 28'h0400020; pc_plus4_d = 32'h1000_0104;
    cycle();
    clear_req();
    vectors++; if (pc_f !== 32'h1040_0020) begin miscompares++; $display("FAIL jump_pc: got %h expected 10400020", pc_f); end
    vectors++; if (flush_d !== 1'b1) begin miscompares++; $display("FAIL jump_flush: got %b expected 1", flush_d); end
    cycle();
    vectors++; if (pc_f !== 32'h1040_0024) begin miscompares++; $display("FAIL jump_next_pc: got %h expected 10400024", pc_f); end
    vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL jump_flush_end: got %b expected 0", flush_d); end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] hold;
    hold = m_pc;
    stall_f = 1'b1; branch_en = 1'b1; branch_target = 32'h0000_2000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      branch_en = 1'b0;
      vectors++; if (pc_f !== hold) begin miscompares++; $display("FAIL stall_hold_pc%0d: got %h expected %h", i, pc_f, hold); end
      vectors++; if (redirect_pending !== 1'b1) begin miscompares++; $display("FAIL stall_pending%0d: got %b expected 1", i, redirect_pending); end
      vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL stall_flush%0d: got %b expected 0", i, flush_d); end
    end
    stall_f = 1'b0;
    cycle();
    vectors++; if (pc_f !== 32'h0000_2000) begin miscompares++; $display("FAIL release_pc: got %h expected 00002000", pc_f); end
    vectors++; if (flush_d !== 1'b1) begin miscompares++; $display("FAIL release_flush: got %b expected 1", flush_d); end
    vectors++; if (redirect_pending !== 1'b0) begin miscompares++; $display("FAIL release_pending: got %b expected 0", redirect_pending); end
    cycle();
    vectors++; if (pc_f !== 32'h0000_2004) begin miscompares++; $display("FAIL release_next_pc: got %h expected 00002004", pc_f); end
    vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL release_flush_end: got %b expected 0", flush_d); end
  endtask

  task automatic test_priority();
    jr_en = 1'b1; jr_target = 32'h0000_3000;
    jump_en = 1'b1; jump_addr28 = 28'h0400020; pc_plus4_d = 32'h1000_0104;
    branch_en = 1'b1; branch_target = 32'h0000_5000;
    cycle();
    clear_req();
    vectors++; if (pc_f !== 32'h0000_3000) begin miscompares++; $display("FAIL prio_pc: got %h expected 00003000", pc_f); end
    vectors++; if (flush_d !== 1'b1) begin miscompares++; $display("FAIL prio_flush: got %b expected 1", flush_d); end
    cycle();
    vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL prio_flush_end: got %b expected 0", flush_d); end
    vectors++; if (pc_f !== 32'h0000_3004) begin miscompares++; $display("FAIL prio_next_pc: got %h expected 00003004", pc_f); end
  endtask

  task automatic test_misalign_reset();
    jr_en = 1'b1; jr_target = 32'h0000_4002;
    cycle();
    clear_req();
    vectors++; if (pc_f !== 32'h0000_4000) begin miscompares++; $display("FAIL misalign_pc: got %h expected 00004000", pc_f); end
    vectors++; if (addr_err !== 1'b1) begin miscompares++; $display("FAIL misalign_err: got %b expected 1", addr_err); end
    for (int i = 0; i < 10; i++) cycle();
    vectors++; if (addr_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", addr_err); end
    vectors++; if (pc_f !== 32'h0000_4028) begin miscompares++; $display("FAIL err_sticky_pc: got %h expected 00004028", pc_f); end
    stall_f = 1'b1; branch_en = 1'b1; branch_target = 32'h0000_6000;
    cycle();
    branch_en = 1'b0;
    vectors++; if (redirect_pending !== 1'b1) begin miscompares++; $display("FAIL pend_before_rst: got %b expected 1", redirect_pending); end
    rst = 1'b0;
    cycle();
    vectors++; if (pc_f !== RESET_PC) begin miscompares++; $display("FAIL rst_pend_pc: got %h expected %h", pc_f, RESET_PC); end
    vectors++; if (redirect_pending !== 1'b0) begin miscompares++; $display("FAIL rst_pend_pending: got %b expected 0", redirect_pending); end
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL rst_err_clear: got %b expected 0", addr_err); end
    rst = 1'b1; stall_f = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      cycle();
      vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL post_rst_flush%0d: got %b expected 0", i, flush_d); end
      vectors++; if (pc_f !== RESET_PC + 32'(4 * i)) begin miscompares++; $display("FAIL post_rst_pc%0d: got %h expected %h", i, pc_f, RESET_PC + 32'(4 * i)); end
    end
  endtask

  task automatic test_wrap();
    jr_en = 1'b1; jr_target = 32'hFFFF_FFFC;
    cycle();
    clear_req();
    vectors++; if (pc_f !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc: got %h expected fffffffc", pc_f); end
    vectors++; if (pc_plus4_f !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_plus4: got %h expected 00000000", pc_plus4_f); end
    vectors++; if (addr_err !== 1'b0) begin miscompares++; $display("FAIL wrap_err: got %b expected 0", addr_err); end
    cycle();
    vectors++; if (pc_f !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_next_pc: got %h expected 00000000", pc_f); end
    vectors++; if (flush_d !== 1'b0) begin miscompares++; $display("FAIL wrap_flush: got %b expected 0", flush_d); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst           = ($urandom_range(0, 63) != 0);
      stall_f       = ($urandom_range(0, 9) < 4);
      jr_en         = ($urandom_range(0, 9) == 0);
      jump_en       = ($urandom_range(0, 9) == 0);
      branch_en     = ($urandom_range(0, 7) == 0);
      jr_target     = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      jump_addr28   = 28'($urandom);
      pc_plus4_d    = $urandom;
      branch_target = $urandom;
      cycle();
      vectors++; if (pc_f !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc_f, m_pc); end
      vectors++; if (pc_plus4_f !== m_pc + 32'd4) begin miscompares++; $display("FAIL rnd_plus4[%0d]: got %h expected %h", n, pc_plus4_f, m_pc + 32'd4); end
      vectors++; if (flush_d !== m_flush) begin miscompares++; $display("FAIL rnd_flush[%0d]: got %b expected %b", n, flush_d, m_flush); end
      vectors++; if (redirect_pending !== (m_pend_q.size() != 0)) begin miscompares++; $display("FAIL rnd_pending[%0d]: got %b expected %b", n, redirect_pending, m_pend_q.size() != 0); end
      vectors++; if (addr_err !== m_err) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, addr_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_stall_redirect();
    test_priority();
    test_misalign_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
